// File: rtl/delayed_reset_cycle_counter.sv
// Reset-release delay chain plus a free-running cycle counter.
// The counter is held at zero while the delayed reset is asserted.
module delayed_reset_cycle_counter #(
    parameter int unsigned num_stages_p = 3,
    parameter int unsigned ctr_width_p  = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   done_i,
    output logic                   reset_o,
    output logic [ctr_width_p-1:0] ctr_r_o
);

    if ((num_stages_p < 1) || (num_stages_p > 16)) begin : g_bad_stages
        $error("num_stages_p must be in the range 1..16");
    end

    logic [num_stages_p-1:0] s_q, s_d;
    logic [ctr_width_p-1:0]  ctr_q, ctr_d;

    always_comb begin
        s_d    = s_q;
        s_d[0] = ~done_i;
        for (int unsigned k = 1; k < num_stages_p; k++) begin
            s_d[k] = s_q[k-1];
        end
    end

    // Uses the current chain output, so counting starts one cycle after release.
    always_comb begin
        ctr_d = ctr_q + ctr_width_p'(1);
        if (s_q[num_stages_p-1]) begin
            ctr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s_q   <= '1;
            ctr_q <= '0;
        end else begin
            s_q   <= s_d;
            ctr_q <= ctr_d;
        end
    end

    assign reset_o = s_q[num_stages_p-1];
    assign ctr_r_o = ctr_q;

endmodule

// File: tb/tb_delayed_reset_cycle_counter.sv
// Directed bench: main instance (N=3, 32-bit), wrap instance (N=3, 4-bit)
// and single-stage instance (N=1) share one clock and one global reset.
module tb_delayed_reset_cycle_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        done_a = 1'b0;
    logic        done_b = 1'b0;
    logic        done_c = 1'b0;
    logic        reset_a, reset_b, reset_c;
    logic [31:0] ctr_a, ctr_c;
    logic [3:0]  ctr_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    delayed_reset_cycle_counter #(.num_stages_p(3), .ctr_width_p(32)) u_main (
        .clk_i   (clk),
        .reset_i (reset),
        .done_i  (done_a),
        .reset_o (reset_a),
        .ctr_r_o (ctr_a)
    );

    delayed_reset_cycle_counter #(.num_stages_p(3), .ctr_width_p(4)) u_wrap (
        .clk_i   (clk),
        .reset_i (reset),
        .done_i  (done_b),
        .reset_o (reset_b),
        .ctr_r_o (ctr_b)
    );

    delayed_reset_cycle_counter #(.num_stages_p(1), .ctr_width_p(32)) u_one (
        .clk_i   (clk),
        .reset_i (reset),
        .done_i  (done_c),
        .reset_o (reset_c),
        .ctr_r_o (ctr_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Power-up: reset held, then released with done low.
        #1 reset = 1'b1;
        #1;
        chk("async_rst_reset_a", 32'(reset_a), 32'd1);
        chk("async_rst_ctr_a", ctr_a, 32'd0);
        repeat (16) tick();
        chk("rst_hold_reset_a", 32'(reset_a), 32'd1);
        chk("rst_hold_ctr_b", 32'(ctr_b), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_reset_a", 32'(reset_a), 32'd1);
            chk("idle_ctr_a", ctr_a, 32'd0);
        end
        chk("idle_reset_b", 32'(reset_b), 32'd1);
        chk("idle_reset_c", 32'(reset_c), 32'd1);

        // Release timing: done set before edge E.
        done_a = 1'b1;
        tick();
        chk("rel_e0_reset_a", 32'(reset_a), 32'd1);
        tick();
        chk("rel_e1_reset_a", 32'(reset_a), 32'd1);
        tick();
        chk("rel_e2_reset_a", 32'(reset_a), 32'd0);
        chk("rel_ctr0", ctr_a, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rel_ctr_seq", ctr_a, 32'(i));
        end

        // Count up to 100, then async reset between edges.
        repeat (97) tick();
        chk("ctr_at_100", ctr_a, 32'd100);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_reset_a", 32'(reset_a), 32'd1);
        chk("mid_rst_ctr_a", ctr_a, 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("refill_e0_reset_a", 32'(reset_a), 32'd1);
        chk("refill_e0_ctr_a", ctr_a, 32'd0);
        tick();
        chk("refill_e1_reset_a", 32'(reset_a), 32'd1);
        tick();
        chk("refill_e2_reset_a", 32'(reset_a), 32'd0);
        chk("refill_e2_ctr_a", ctr_a, 32'd0);
        tick();
        chk("refill_ctr1", ctr_a, 32'd1);

        // done drop while counting at 50.
        repeat (49) tick();
        chk("ctr_at_50", ctr_a, 32'd50);
        done_a = 1'b0;
        tick();
        chk("drop_ctr51", ctr_a, 32'd51);
        chk("drop_e0_reset_a", 32'(reset_a), 32'd0);
        tick();
        chk("drop_ctr52", ctr_a, 32'd52);
        chk("drop_e1_reset_a", 32'(reset_a), 32'd0);
        tick();
        chk("drop_ctr53", ctr_a, 32'd53);
        chk("drop_e2_reset_a", 32'(reset_a), 32'd1);
        tick();
        chk("drop_clear", ctr_a, 32'd0);
        tick();
        chk("drop_hold", ctr_a, 32'd0);
        chk("drop_hold_reset_a", 32'(reset_a), 32'd1);

        // 4-bit wrap.
        done_b = 1'b1;
        repeat (3) tick();
        chk("wrap_release", 32'(reset_b), 32'd0);
        for (int i = 0; i < 18; i++) begin
            chk("wrap_seq", 32'(ctr_b), 32'(i % 16));
            tick();
        end

        // Single-stage 1-cycle pulse.
        done_c = 1'b1;
        tick();
        chk("pulse_open_reset_c", 32'(reset_c), 32'd0);
        chk("pulse_open_ctr_c", ctr_c, 32'd0);
        done_c = 1'b0;
        tick();
        chk("pulse_close_reset_c", 32'(reset_c), 32'd1);
        chk("pulse_close_ctr_c", ctr_c, 32'd1);
        tick();
        chk("pulse_after_reset_c", 32'(reset_c), 32'd1);
        chk("pulse_after_ctr_c", ctr_c, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
